regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file (32 register32 instances) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake; accepted writes are decoded into a registered one-hot per-register write enable plus registered write data.
- Sits between the pipeline writeback sources (e.g. ALU and load unit) and the register-file write-enable/data nets.

Parameters:
- NUM_REQ, 2, number of write requesters.
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, registers driven; must equal 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the accepted-write counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; combinational.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; same packing.
- hold  in  1  freeze: no grants while high.
- reg_wrenable  out  NUM_REGS  registered one-hot write enable, one bit per register.
- reg_wrdata  out  DATA_WIDTH  registered write data, shared by all registers.
- grant_id  out  clog2(NUM_REQ)  registered index of the last accepted requester.
- wr_count  out  CNT_WIDTH  accepted transfers, saturating.

Behaviour:
- Reset (reset_n low, asynchronous, overrides everything):
  - reg_wrenable=0, reg_wrdata=0, grant_id=0, wr_count=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while reset_n is low.
- Arbitration (combinational):
  - If hold=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NUM_REQ.
  - At most one req_ready bit is high per cycle.
  - No valid requests, or hold=1: req_ready=0.
- Transfer: occurs when req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - reg_wrenable <= one-hot(req_addr[i]); all-zero if req_addr[i]==0, because r0 is never written.
  - reg_wrdata <= req_data[i].
  - grant_id <= i.
  - ptr <= (i+1) mod NUM_REQ.
  - wr_count <= wr_count+1; saturates at all-ones. Address-0 writes are counted.
- Idle edge (no transfer): reg_wrenable <= 0. reg_wrdata, grant_id, ptr and wr_count hold.
- Latency:
  - reg_wrenable is high for exactly one cycle, the cycle after the handshake.
  - The register file captures on the following edge, so data is readable 2 edges after the handshake.
- Back-to-back: a new transfer is allowed every cycle; reg_wrenable is re-decoded each edge with no bubble.
- Requester rules:
  - valid/addr/data must be held stable until ready is seen.
  - Dropping valid before ready is legal; the request is lost and the arbiter is unaffected.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0…
  - A requester waits at most NUM_REQ-1 grants.
- hold: blocks new grants, ptr unchanged. An enable already registered still completes its single cycle.
- Reset mid-operation: a registered pending enable is cleared immediately (the write is dropped); ptr returns to 0.
- reg_wrenable is never multi-hot. Out-of-range decode is impossible because NUM_REGS==2**ADDR_WIDTH.

Decomposition:
- Package regfile_pkg:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants.
  - ZERO_REG address constant (0).
  - reg_addr_t / reg_data_t typedefs.
- Sub-module rr_priority_arbiter (NUM_REQ):
  - inputs req, ptr; outputs grant one-hot and grant index; combinational.
  - The top level holds the ptr register, output registers, decoder and counter.

Test Plan:
1. Reset then single write: req_valid=01, addr0=5, data0=0xDEADBEEF -> req_ready=01 the same cycle; next cycle reg_wrenable=0x00000020, reg_wrdata=0xDEADBEEF, grant_id=0, wr_count=1; following cycle reg_wrenable=0.
2. Contention: both valid continuously, addr0=1, addr1=2 -> grants alternate 0,1,0,1; reg_wrenable sequence 0x2,0x4,0x2,0x4 with no idle cycles.
3. Zero register: addr=0, data=0x12345678 accepted -> reg_wrenable stays 0; wr_count increments; grant_id updated.
4. hold=1 for 3 cycles with req_valid=11 -> req_ready=00, reg_wrenable=0, ptr unchanged; after hold drops, the grant goes to the requester ptr pointed to before hold.
5. reset_n pulsed low between the handshake edge and the next edge -> reg_wrenable clears immediately, wr_count=0, and the first grant after release goes to requester 0.
6. Saturation: preload via 65535 transfers, then one more -> wr_count stays 0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry constants and shared typedefs
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // r0 is hardwired to zero and never receives a write enable
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester-side write request bus
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          hold;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output hold,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  hold,
    output req_ready
  );

endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - combinational round-robin priority search from ptr
module rr_priority_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin share of the register-file write port
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_write_arbiter_if.slave req,
  output logic [NUM_REGS-1:0]   reg_wrenable,
  output logic [DATA_WIDTH-1:0] reg_wrdata,
  output logic [IDX_W-1:0]      grant_id,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  import regfile_pkg::*;

  logic [IDX_W-1:0]      ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      gidx;
  logic [NUM_REQ-1:0]    ready;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   dec;
  logic [IDX_W-1:0]      ptr_next;

  rr_priority_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Ready is suppressed during reset so nothing upstream believes a write landed
  assign ready         = (reset_n && !req.hold) ? grant : '0;
  assign req.req_ready = ready;
  assign transfer      = |(req.req_valid & ready);

  assign sel_addr = req.req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req.req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_next = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

  always_comb begin
    dec = '0;
    if (sel_addr != ADDR_WIDTH'(ZERO_REG))
      dec[sel_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wrenable <= '0;
      reg_wrdata   <= '0;
      grant_id     <= '0;
      wr_count     <= '0;
      ptr          <= '0;
    end else if (transfer) begin
      reg_wrenable <= dec;
      reg_wrdata   <= sel_data;
      grant_id     <= gidx;
      ptr          <= ptr_next;
      if (wr_count != '1)
        wr_count <= wr_count + 1'b1;
    end else begin
      reg_wrenable <= '0;
    end
  end

endmodule
